// File: rtl/arb_mux_rr.sv
// arb_mux_rr: registered N:1 multiplexer with valid/ready handshakes.
// Fixed mode forwards the channel named by sel. Round-robin mode grants
// the first requesting channel after the most recently granted one.
// Grant logic is combinational; the output word sits in a single-entry
// register that reloads in the same cycle it drains.
module arb_mux_rr #(
    parameter int NCH = 4,
    parameter int W   = 4,
    parameter int SW  = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    input  logic [NCH-1:0]     in_valid,
    input  logic [NCH*W-1:0]   in_data,
    output logic [NCH-1:0]     in_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [SW-1:0]      out_ch,
    input  logic               out_ready
);

    logic               r_valid;
    logic [W-1:0]       r_data;
    logic [SW-1:0]      r_ch;
    logic [SW-1:0]      r_last;

    logic [NCH-1:0]     w_elig;
    logic               w_found;
    logic [SW-1:0]      w_gidx;
    logic [W-1:0]       w_gdata;
    logic               w_load_ok;
    logic               w_hs;

    // Channel index base+off, wrapped modulo NCH (NCH need not be a power of two).
    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int off);
        int t;
        t = (int'(base) + off) % NCH;
        return SW'(t);
    endfunction

    // Eligible channels: all requesters in round-robin, only sel in fixed mode.
    // A sel outside 0..NCH-1 matches no channel, so nothing is eligible.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NCH; i++) begin
            if (mode) begin
                w_elig[i] = in_valid[i];
            end else begin
                w_elig[i] = in_valid[i] && (sel == SW'(i));
            end
        end
    end

    // Priority search starting at last+1; in fixed mode at most one bit is set.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!w_found && w_elig[wrap_idx(r_last, k)]) begin
                w_found = 1'b1;
                w_gidx  = wrap_idx(r_last, k);
            end
        end
    end

    // Data of the winning channel.
    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gidx == SW'(i)) begin
                w_gdata = in_data[i*W +: W];
            end
        end
    end

    // Register may load when empty or draining; nothing is taken while in reset.
    assign w_load_ok = !r_valid || out_ready;
    assign w_hs      = rst_n && w_found && w_load_ok;

    // One-hot ready toward the winner, zero otherwise.
    always_comb begin
        in_ready = '0;
        if (w_hs) begin
            in_ready[w_gidx] = 1'b1;
        end
    end

    // Output register and fairness history; last follows grants in both modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_last  <= SW'(NCH - 1);
        end else if (w_hs) begin
            r_valid <= 1'b1;
            r_data  <= w_gdata;
            r_ch    <= w_gidx;
            r_last  <= w_gidx;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: scenario tasks for arb_mux_rr (NCH=4/W=4 and NCH=3/W=8).
// Expected output words are queued when a grant is predicted and compared
// by a negedge monitor whenever the consumer takes a word.
module tb_arb_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [3:0]  in_valid = '0;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready = 1'b0;

    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [2:0]  iv3 = '0;
    logic [23:0] id3;
    logic [2:0]  ir3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        or3 = 1'b1;

    logic [3:0]  d4 [4] = '{4'h3, 4'h5, 4'hA, 4'hC};
    logic [7:0]  d3 [3] = '{8'hC3, 8'h5A, 8'h81};

    logic [5:0]  q4 [$];
    logic [9:0]  q3 [$];
    logic [5:0]  e4;
    logic [9:0]  e3;

    int n_checks = 0;
    int n_fail   = 0;

    assign in_data = {d4[3], d4[2], d4[1], d4[0]};
    assign id3     = {d3[2], d3[1], d3[0]};

    always #5 clk = ~clk;

    arb_mux_rr #(.NCH(4), .W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    arb_mux_rr #(.NCH(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(iv3), .in_data(id3), .in_ready(ir3),
        .out_valid(ov3), .out_data(od3), .out_ch(oc3),
        .out_ready(or3)
    );

    // Scoreboard for the 4-channel instance.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (q4.size() == 0) begin
                n_fail++;
                $display("FAIL sb4_unexpected: got ch=%0d data=%h, expected no word", out_ch, out_data);
            end else begin
                e4 = q4.pop_front();
                if ({out_ch, out_data} !== e4) begin
                    n_fail++;
                    $display("FAIL sb4_word: got ch=%0d data=%h, expected ch=%0d data=%h",
                             out_ch, out_data, e4[5:4], e4[3:0]);
                end
            end
        end
    end

    // Scoreboard for the 3-channel instance.
    always @(negedge clk) begin
        if (rst_n && ov3 && or3) begin
            n_checks++;
            if (q3.size() == 0) begin
                n_fail++;
                $display("FAIL sb3_unexpected: got ch=%0d data=%h, expected no word", oc3, od3);
            end else begin
                e3 = q3.pop_front();
                if ({oc3, od3} !== e3) begin
                    n_fail++;
                    $display("FAIL sb3_word: got ch=%0d data=%h, expected ch=%0d data=%h",
                             oc3, od3, e3[9:8], e3[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0;
        iv3 = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid = '0;
        iv3 = '0;
        out_ready = 1'b1;
        or3 = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = 4'hF; out_ready = 1'b1;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", out_data); end
        n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL rst_ch: got %0d expected 0", out_ch); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b expected 0000", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid: got %b expected 0", out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant: got %b expected 0001", in_ready); end
        q4.push_back({2'd0, d4[0]});
        tick();
        in_valid = '0; out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL rst_async_data: got %h expected 0", out_data); end
        n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL rst_async_ch: got %0d expected 0", out_ch); end
        q4.delete();
        tick();
        rst_n = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_regrant: got %b expected 0001", in_ready); end
        q4.push_back({2'd0, d4[0]});
        tick();
        drain();
        n_checks++; if (q4.size() != 0) begin n_fail++; $display("FAIL rst_sb_left: got %0d words expected 0", q4.size()); end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fix_ready: got %b expected 0100", in_ready); end
        q4.push_back({2'd2, d4[2]});
        tick();
        sel = 2'd3; in_valid = 4'b0111;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fix_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 4'hA) begin n_fail++; $display("FAIL fix_data: got %h expected a", out_data); end
        n_checks++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL fix_ch: got %0d expected 2", out_ch); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL fix_sel3_ready: got %b expected 0000", in_ready); end
        tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fix_fall: got %b expected 0", out_valid); end
        n_checks++; if ({out_ch, out_data} !== {2'd2, 4'hA}) begin n_fail++; $display("FAIL fix_hold: got ch=%0d data=%h expected ch=2 data=a", out_ch, out_data); end
        tick();
        drain();
        n_checks++; if (q4.size() != 0) begin n_fail++; $display("FAIL fix_sb_left: got %0d words expected 0", q4.size()); end
    endtask

    task automatic test_rr_rotation();
        int seq [6] = '{0, 1, 3, 0, 1, 3};
        logic [3:0] oh;
        do_reset();
        mode = 1'b1; in_valid = 4'b1011; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            oh = 4'b0001 << seq[i];
            n_checks++;
            if (in_ready !== oh) begin n_fail++; $display("FAIL rr_rot_%0d: got %b expected %b", i, in_ready, oh); end
            q4.push_back({2'(seq[i]), d4[seq[i]]});
            tick();
        end
        drain();
        n_checks++; if (q4.size() != 0) begin n_fail++; $display("FAIL rr_sb_left: got %0d words expected 0", q4.size()); end
    endtask

    task automatic test_back_to_back();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first: got %b expected 0001", in_ready); end
        q4.push_back({2'd0, d4[0]});
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_%0d: got %b expected 0000", i, in_ready); end
            n_checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, d4[0]})
                begin n_fail++; $display("FAIL bp_hold_%0d: got v=%b ch=%0d data=%h expected v=1 ch=0 data=%h", i, out_valid, out_ch, out_data, d4[0]); end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_resume: got %b expected 0010", in_ready); end
        q4.push_back({2'd1, d4[1]});
        tick();
        @(negedge clk);
        n_checks++; if ({out_valid, out_ch} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL bp_nobubble: got v=%b ch=%0d expected v=1 ch=1", out_valid, out_ch); end
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next: got %b expected 0100", in_ready); end
        q4.push_back({2'd2, d4[2]});
        tick();
        drain();
        n_checks++; if (q4.size() != 0) begin n_fail++; $display("FAIL bp_sb_left: got %0d words expected 0", q4.size()); end
    endtask

    task automatic test_mode_switch();
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL ms_rr1: got %b expected 0010", in_ready); end
        q4.push_back({2'd1, d4[1]});
        tick();
        mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
        @(negedge clk);
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL ms_fix0: got %b expected 0001", in_ready); end
        q4.push_back({2'd0, d4[0]});
        tick();
        mode = 1'b1;
        @(negedge clk);
        n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL ms_word_kept: got ch=%0d expected 0", out_ch); end
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL ms_rr_after: got %b expected 0010", in_ready); end
        q4.push_back({2'd1, d4[1]});
        tick();
        drain();
        n_checks++; if (q4.size() != 0) begin n_fail++; $display("FAIL ms_sb_left: got %0d words expected 0", q4.size()); end
    endtask

    task automatic test_param_sweep();
        int seq [7] = '{0, 1, 2, 0, 2, 0, 2};
        logic [2:0] oh;
        do_reset();
        mode3 = 1'b0; sel3 = 2'd3; iv3 = 3'b111; or3 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if ({ov3, ir3} !== 4'b0000) begin n_fail++; $display("FAIL n3_sel3_%0d: got v=%b ready=%b expected v=0 ready=000", i, ov3, ir3); end
            tick();
        end
        mode3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) iv3 = 3'b101;
            @(negedge clk);
            oh = 3'b001 << seq[i];
            n_checks++;
            if (ir3 !== oh) begin n_fail++; $display("FAIL n3_rot_%0d: got %b expected %b", i, ir3, oh); end
            q3.push_back({2'(seq[i]), d3[seq[i]]});
            tick();
        end
        drain();
        n_checks++; if (q3.size() != 0) begin n_fail++; $display("FAIL n3_sb_left: got %0d words expected 0", q3.size()); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_back_to_back();
        test_mode_switch();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/arb_mux_rr.md
# arb_mux_rr

Parametrised, registered N:1 multiplexer with per-channel valid/ready handshakes and two selection modes. In fixed mode it forwards the channel named by `sel`. In round-robin mode it arbitrates fairly among requesting channels. It replaces hard-wired 4:1 bit selectors wherever several sources (LED, tone, score, sequence words) compete for one sink and need back-pressure, and it sits between the source blocks and the single consumer.

## Interface
- `NCH`, 4, number of input channels; must be ≥2.
- `W`, 4, data width per channel.
- `SW`, `$clog2(NCH)`, width of the select and channel-ID fields; derived, never overridden.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = fixed select via `sel`; 1 = round-robin.
- `sel`  in  SW  channel index used in fixed mode; ignored in round-robin mode.
- `in_valid`  in  NCH  bit i set means channel i offers data.
- `in_data`  in  NCH*W  channel i occupies bits [i*W +: W].
- `in_ready`  out  NCH  one-hot or zero; bit i set means channel i's word is taken this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  W  registered word.
- `out_ch`  out  SW  index of the source channel of `out_data`.
- `out_ready`  in  1  the consumer accepts the word this cycle.

## Operation
- Single-entry output register. The register can load when it is empty or is being drained: `load_ok = !out_valid | out_ready`.
- Eligibility:
  - Fixed mode: only channel `sel` is eligible, and only if `in_valid[sel]`.
  - If `sel` ≥ NCH, no channel is eligible.
- Round-robin mode:
  - Every channel with `in_valid` set is eligible.
  - Priority starts at `last+1` and wraps modulo NCH, where `last` is the most recently granted channel.
  - The search wraps from NCH-1 to 0.
- Grant is computed combinationally. `in_ready[g]` = 1 only when an eligible winner g exists and `load_ok` holds. All other `in_ready` bits are 0.
- A handshake (`in_valid[g] & in_ready[g]`) has the following effects at the next edge:
  - `out_data` ← channel g data.
  - `out_ch` ← g.
  - `out_valid` ← 1.
  - `last` ← g, in both modes, so switching modes keeps the fairness history.
- If `out_ready` is asserted and no handshake occurs, the next edge sets `out_valid` ← 0. `out_data` and `out_ch` hold their last values.
- If `out_valid` is 1 and `out_ready` is 0, the register holds. `out_data` and `out_ch` stay stable, and all `in_ready` bits are 0.
- If `out_ready` and a new grant occur in the same cycle, the old word is consumed and the new word loads at that edge. This gives no bubble and full throughput of one word per cycle.
- A `mode` or `sel` change never alters a word already in the register. It affects only the next grant.
- `in_ready` depends combinationally on `in_valid`, `mode`, `sel` and `out_ready`. There is no combinational path from any input to `out_*`.

## Timing
- Reset values (asynchronous assertion; release synchronised externally):
  - `out_valid` = 0.
  - `out_data` = 0.
  - `out_ch` = 0.
  - `last` = NCH-1, so channel 0 has the highest priority after reset.
  - `in_ready` = 0.
- Latency is one cycle from input handshake to `out_valid`/`out_data`.
- Throughput is one word per cycle while `out_ready` stays high.
- A reset mid-transfer discards the registered word. No handshake completes in the reset cycle.
- Fairness: with k channels continuously valid in round-robin mode and `out_ready` = 1, each channel is granted exactly once in every k consecutive grants.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `out_valid`=1 → outputs go to 0 immediately, without a clock. After release with `in_valid`=4'b1111 in round-robin mode, the first grant is ch0.
- **Fixed mode:** `mode`=0, `sel`=2, `in_valid`=4'b1111, ch2 data=4'hA, `out_ready`=1:
  - `in_ready`=4'b0100.
  - Next cycle `out_data`=4'hA, `out_ch`=2.
  - Setting `sel`=3 with `in_valid[3]`=0 gives `in_ready`=0, and `out_valid` falls after one cycle.
- **Round-robin rotation:** `mode`=1, `in_valid`=4'b1011, `out_ready`=1 held → `out_ch` sequence 0,1,3,0,1,3; ch2 is never granted.
- **Back-pressure:** `out_valid`=1 with `out_ready`=0 for 3 cycles while `in_valid`=4'b1111 → `in_ready`=0 and `out_data`/`out_ch` unchanged. When `out_ready` rises, the next channel in rotation loads on the same edge, with no idle cycle.
- **Mode switch:** grant ch1 in round-robin, then switch to `mode`=0, `sel`=0, then back to `mode`=1 with all channels valid → the next round-robin grant is ch1, because `last`=0 came from the fixed-mode grant.
- **Parameter sweep:** repeat the rotation test with NCH=3, W=8, and `sel`=3 in fixed mode → no grant, and the wrap goes 2→0.
